trivia_buzzer_arbiter: RTL

Debounces the four player push-buttons, arbitrates the first valid press after the host arms a round, and latches the winner and response time for the Nios II. Sits beside the key PIO on the Avalon-MM fabric and replaces raw key polling for buzz-in. Raises a level interrupt on lock-out. The host re-arms it each question.

---
 rtl/trivia_buzzer_pkg.sv | 20 ++
 rtl/trivia_key_debounce.sv | 49 ++++
 rtl/trivia_buzzer_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/trivia_buzzer_pkg.sv
// Shared types and register map for the trivia buzzer arbiter.
// Imported by the top level and the per-key debounce block.
package trivia_buzzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_TIMER   = 2'd3;

    localparam int CTRL_ARM    = 0;
    localparam int CTRL_DISARM = 1;
    localparam int CTRL_IRQ_EN = 2;

endpackage

// File: rtl/trivia_key_debounce.sv
// One player key: 2-FF synchroniser, stable-count debounce and a
// single-cycle press pulse on the debounced 0->1 transition.
module trivia_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1, r_sync2, r_level, r_press;
    logic [CW-1:0] r_cnt;
    logic          w_pressed;

    assign w_pressed = ~r_sync2;
    assign o_level   = r_level;
    assign o_press   = r_press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // Synchroniser starts at the released (high) level.
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (w_pressed != r_level) begin
                if (r_cnt == CNT_MAX) begin
                    r_level <= w_pressed;
                    r_press <= w_pressed;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/trivia_buzzer_arbiter.sv
// Buzz-in arbiter: debounced keys, fixed-priority lock-out FSM,
// response timer and an Avalon-MM register file with level irq.
module trivia_buzzer_arbiter
    import trivia_buzzer_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [1:0]          address,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic                irq
);
    logic [NUM_KEYS-1:0] w_level, w_press, w_hit;
    logic [1:0]          w_win;
    logic                w_ctrl_wr, w_mask_wr, w_lock;
    logic [31:0]         w_status;

    state_t              r_state;
    logic [1:0]          r_winner;
    logic [31:0]         r_timer;
    logic [NUM_KEYS-1:0] r_mask;
    logic                r_irq_en, r_irq;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        trivia_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .reset   (reset),
            .i_key_n (key_n[g]),
            .o_level (w_level[g]),
            .o_press (w_press[g])
        );
    end

    assign w_hit     = w_press & r_mask;
    assign w_ctrl_wr = write && (address == ADDR_CONTROL);
    assign w_mask_wr = write && (address == ADDR_MASK);
    // A host write in the same cycle as a press always wins.
    assign w_lock    = (r_state == ST_ARMED) && (|w_hit) && !w_ctrl_wr;
    assign irq       = r_irq;

    always_comb begin
        w_win = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (w_hit[i]) w_win = 2'(i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_winner <= '0;
            r_timer  <= '0;
            r_mask   <= '1;
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_mask_wr)
                r_mask <= writedata[NUM_KEYS-1:0];

            if (w_ctrl_wr) begin
                r_irq_en <= writedata[CTRL_IRQ_EN];
                if (writedata[CTRL_DISARM]) begin
                    r_state <= ST_IDLE;
                    r_irq   <= 1'b0;
                end else if (writedata[CTRL_ARM]) begin
                    r_state  <= ST_ARMED;
                    r_winner <= '0;
                    r_irq    <= 1'b0;
                end else begin
                    r_irq <= (r_state == ST_LOCKED) && writedata[CTRL_IRQ_EN];
                end
            end else if (w_lock) begin
                r_state  <= ST_LOCKED;
                r_winner <= w_win;
                r_irq    <= r_irq_en;
            end

            if (w_ctrl_wr && writedata[CTRL_ARM] && !writedata[CTRL_DISARM])
                r_timer <= '0;
            else if (r_state == ST_ARMED && !w_lock && r_timer != '1)
                r_timer <= r_timer + 32'd1;
        end
    end

    assign w_status = {20'b0, w_level, 2'b0, r_winner, 1'b0, r_irq_en, r_state};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_STATUS: readdata <= w_status;
                ADDR_MASK:   readdata <= {{(32-NUM_KEYS){1'b0}}, r_mask};
                ADDR_TIMER:  readdata <= r_timer;
                default:     readdata <= '0;
            endcase
        end
    end

endmodule
